// File: rtl/tdm_lane_pkg.sv
// Shared constants, mode encoding and lane-slice helper for the TDM lane router.
`ifndef TDM_LANE_PKG_SV
`define TDM_LANE_PKG_SV

// Selects lane k (w bits wide) out of a flat lane bus.
`define TDM_LANE(bus, k, w) bus[(k)*(w) +: (w)]

package tdm_lane_pkg;

   localparam int unsigned DEF_WIDTH    = 4;
   localparam int unsigned DEF_CHANNELS = 4;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

endpackage

`endif

// File: rtl/tdm_route_table.sv
// Per-source destination table: identity after reset, one write port, one async read port.
module tdm_route_table
   import tdm_lane_pkg::*;
#(
   parameter int unsigned CHANNELS = DEF_CHANNELS,
   parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_we,
   input  logic [SEL_W-1:0] i_waddr,
   input  logic [SEL_W-1:0] i_wdata,
   input  logic [SEL_W-1:0] i_raddr,
   output logic [SEL_W-1:0] o_rdata
);

   logic [SEL_W-1:0] r_route [CHANNELS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            r_route[k] <= SEL_W'(k);
         end
      end else if (i_we) begin
         r_route[i_waddr] <= i_wdata;
      end
   end

   // Read sees the pre-write value on a same-edge write.
   assign o_rdata = r_route[i_raddr];

endmodule

// File: rtl/tdm_lane_router.sv
// Clocked CHANNELS x WIDTH lane router with MANUAL and SCAN modes and a 2-stage pipe.
// Optional LANE_PARITY_EN adds carried even parity with a sticky parity_err flag.
module tdm_lane_router
   import tdm_lane_pkg::*;
#(
   parameter  int unsigned WIDTH    = DEF_WIDTH,
   parameter  int unsigned CHANNELS = DEF_CHANNELS,
   parameter  int unsigned DWELL    = 1,
   localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          src_sel,
   input  logic [SEL_W-1:0]          dst_sel,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic                      cfg_we,
   input  logic [SEL_W-1:0]          cfg_addr,
   input  logic [SEL_W-1:0]          cfg_dst,
   output logic [CHANNELS*WIDTH-1:0] dout,
   output logic [CHANNELS-1:0]       dout_valid,
`ifdef LANE_PARITY_EN
   input  logic                      inject_err,
   output logic                      parity_err,
`endif
   output logic [SEL_W-1:0]          slot
);

   localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic                      w_scan;
   logic                      w_last;
   logic [SEL_W-1:0]          w_src_idx;
   logic [SEL_W-1:0]          w_route_rd;
   logic [SEL_W-1:0]          w_dst;
   logic [WIDTH-1:0]          w_lane;
   logic                      w_cap_valid;

   logic [SEL_W-1:0]          r_slot;
   logic [DW_W-1:0]           r_dwell;
   logic [WIDTH-1:0]          r_s1_data;
   logic [SEL_W-1:0]          r_s1_dst;
   logic                      r_s1_valid;
   logic [CHANNELS*WIDTH-1:0] r_dout;
   logic [CHANNELS-1:0]       r_dout_valid;

   tdm_route_table #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_route (
      .clk     (clk),
      .reset   (reset),
      .i_we    (cfg_we),
      .i_waddr (cfg_addr),
      .i_wdata (cfg_dst),
      .i_raddr (r_slot),
      .o_rdata (w_route_rd)
   );

   // Source/destination selection for the S1 capture.
   always_comb begin
      w_scan      = (mode == MODE_SCAN);
      w_last      = (r_dwell == DW_W'(DWELL - 1));
      w_src_idx   = src_sel;
      w_dst       = dst_sel;
      w_cap_valid = 1'b1;
      if (w_scan) begin
         w_src_idx   = r_slot;
         w_dst       = w_route_rd;
         w_cap_valid = w_last;
      end
      w_lane = `TDM_LANE(din, w_src_idx, WIDTH);
   end

   // Slot/dwell counters advance only while scanning; a mode change leaves them intact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot  <= '0;
         r_dwell <= '0;
      end else if (enable && w_scan) begin
         if (w_last) begin
            r_slot  <= r_slot + SEL_W'(1);
            r_dwell <= '0;
         end else begin
            r_dwell <= r_dwell + DW_W'(1);
         end
      end
   end

   // S1: capture lane, destination and valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_data  <= '0;
         r_s1_dst   <= '0;
         r_s1_valid <= 1'b0;
      end else if (enable) begin
         r_s1_data  <= w_lane;
         r_s1_dst   <= w_dst;
         r_s1_valid <= w_cap_valid;
      end else begin
         r_s1_valid <= 1'b0;
      end
   end

   // S2: write the destination lane and pulse its valid bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dout       <= '0;
         r_dout_valid <= '0;
      end else begin
         r_dout_valid <= '0;
         if (enable && r_s1_valid) begin
            `TDM_LANE(r_dout, r_s1_dst, WIDTH) <= r_s1_data;
            r_dout_valid[r_s1_dst]             <= 1'b1;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign slot       = r_slot;

`ifdef LANE_PARITY_EN
   logic r_s1_par;
   logic r_parity_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_par <= 1'b0;
      end else if (enable) begin
         r_s1_par <= (^w_lane) ^ inject_err;
      end
   end

   // Sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_parity_err <= 1'b0;
      end else if (enable && r_s1_valid && ((^r_s1_data) != r_s1_par)) begin
         r_parity_err <= 1'b1;
      end
   end

   assign parity_err = r_parity_err;
`endif

endmodule
